// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the data port, the halt input and the memory side of
//   mem_port_arbiter.
//   fetch : i_req, i_addr  -> arbiter;  i_rdata, i_done, i_stall  <- arbiter
//   data  : d_rd, d_wr, d_addr, d_wdata  -> arbiter;  d_rdata, d_done, d_stall  <- arbiter
//   ctrl  : halt -> arbiter;  mem_dump <- arbiter
//   memory: mem_en, mem_wr, mem_addr, mem_wdata <- arbiter;  mem_rdata -> arbiter
//   The slave modport is the arbiter's view. The master modport is the view of the
//   surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_stall;

  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  logic              halt;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_dump;

  modport slave (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, halt, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
  );

  modport master (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, halt, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_en, mem_wr, mem_addr, mem_wdata, mem_dump
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch port and the data port. It
//   serialises the requests, and data requests win. Each access is sequenced over
//   LATENCY cycles. When it completes, the granted port gets a one-cycle done pulse.
//   After halt, the arbiter drains the access in flight, pulses mem_dump once and
//   then parks.
//   Ports:
//     clk : clock; all state changes on posedge
//     rst : synchronous, active-high reset
//     bus : mem_port_arbiter_if.slave (fetch, data, halt and memory signals)
//   Parameters: LATENCY (>=1, 1 = combinational read), ADDR_W, DATA_W.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit          SINGLE = (LATENCY == 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    DUMP   = 3'd4,
    HALTED = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              halt_seen;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              owner_data_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_done_q, d_done_q;
  logic              mem_en_q, mem_wr_q, mem_dump_q;

  logic              grant, grant_data, capture;
  logic              d_any;

  assign d_any = bus.d_rd | bus.d_wr;

  // Next-state, grant and capture decode
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant      = 1'b0;
    grant_data = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (halt_seen) begin
          state_next = DUMP;
        end else if (d_any) begin
          grant      = 1'b1;
          grant_data = 1'b1;
          state_next = ISSUE;
        end else if (bus.i_req) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next = CNT_W'(LATENCY - 1);
        if (SINGLE) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = halt_seen ? DUMP : IDLE;
      DUMP:    state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // State, access latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      halt_seen    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      owner_data_q <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_dump_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      halt_seen <= halt_seen | bus.halt;

      if (grant) begin
        owner_data_q <= grant_data;
        // A simultaneous read and write is performed as a write
        wr_q         <= grant_data & bus.d_wr;
        addr_q       <= grant_data ? bus.d_addr : bus.i_addr;
        if (grant_data) begin
          wdata_q <= bus.d_wdata;
        end
      end

      // Read data goes straight into the owning port's output register. On a
      // write, d_rdata keeps its old value.
      if (capture) begin
        if (!owner_data_q) begin
          i_rdata_q <= bus.mem_rdata;
        end else if (!wr_q) begin
          d_rdata_q <= bus.mem_rdata;
        end
      end

      // done is high exactly during RESP because capture precedes RESP
      i_done_q   <= capture & ~owner_data_q;
      d_done_q   <= capture & owner_data_q;
      mem_en_q   <= grant;
      mem_wr_q   <= grant & grant_data & bus.d_wr;
      mem_dump_q <= (state_next == DUMP);
    end
  end

  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.i_stall   = bus.i_req & ~i_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_stall   = d_any & ~d_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_dump  = mem_dump_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter.
//   dut  runs with LATENCY=2.
//   dut1 runs with LATENCY=1 and is used only for the read+write case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  int vectors = 0;
  int errors  = 0;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  mem_port_arbiter #(.LATENCY(2), .ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_port_arbiter #(.LATENCY(1), .ADDR_W(16), .DATA_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0;  bus.i_addr = '0;  bus.d_rd = 1'b0;  bus.d_wr = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0; bus.halt = 1'b0;  bus.mem_rdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_rd = 1'b0; bus1.d_wr = 1'b0;
    bus1.d_addr = '0;  bus1.d_wdata = '0; bus1.halt = 1'b0; bus1.mem_rdata = '0;
    tick();
    tick();

    // reset state
    chk("rst_mem_en",   32'(bus.mem_en),   32'h0);
    chk("rst_mem_wr",   32'(bus.mem_wr),   32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_i_done",   32'(bus.i_done),   32'h0);
    chk("rst_d_done",   32'(bus.d_done),   32'h0);
    chk("rst_mem_dump", 32'(bus.mem_dump), 32'h0);
    chk("rst_i_rdata",  32'(bus.i_rdata),  32'h0);
    rst = 1'b0;

    // 1: fetch read
    bus.i_req = 1'b1; bus.i_addr = 16'h0040; bus.mem_rdata = 16'h1234;
    #1;
    chk("t1_c0_i_stall", 32'(bus.i_stall), 32'h1);
    chk("t1_c0_mem_en",  32'(bus.mem_en),  32'h0);
    tick();
    chk("t1_c1_mem_en",   32'(bus.mem_en),   32'h1);
    chk("t1_c1_mem_wr",   32'(bus.mem_wr),   32'h0);
    chk("t1_c1_mem_addr", 32'(bus.mem_addr), 32'h0040);
    chk("t1_c1_i_stall",  32'(bus.i_stall),  32'h1);
    tick();
    chk("t1_c2_mem_en",  32'(bus.mem_en),  32'h0);
    chk("t1_c2_i_done",  32'(bus.i_done),  32'h0);
    chk("t1_c2_i_stall", 32'(bus.i_stall), 32'h1);
    tick();
    chk("t1_c3_i_done",  32'(bus.i_done),  32'h1);
    chk("t1_c3_i_rdata", 32'(bus.i_rdata), 32'h1234);
    chk("t1_c3_i_stall", 32'(bus.i_stall), 32'h0);
    bus.i_req = 1'b0;
    tick();
    chk("t1_c4_i_done", 32'(bus.i_done), 32'h0);
    chk("t1_c4_mem_en", 32'(bus.mem_en), 32'h0);

    // 2: simultaneous fetch and data read; data wins
    bus.i_req = 1'b1; bus.i_addr = 16'h0080;
    bus.d_rd = 1'b1;  bus.d_addr = 16'h0200; bus.mem_rdata = 16'hAAAA;
    tick();
    chk("t2_c1_mem_en",   32'(bus.mem_en),   32'h1);
    chk("t2_c1_mem_addr", 32'(bus.mem_addr), 32'h0200);
    tick();
    chk("t2_c2_i_stall", 32'(bus.i_stall), 32'h1);
    chk("t2_c2_d_stall", 32'(bus.d_stall), 32'h1);
    tick();
    chk("t2_c3_d_done",  32'(bus.d_done),  32'h1);
    chk("t2_c3_d_rdata", 32'(bus.d_rdata), 32'hAAAA);
    chk("t2_c3_i_done",  32'(bus.i_done),  32'h0);
    chk("t2_c3_i_stall", 32'(bus.i_stall), 32'h1);
    bus.d_rd = 1'b0; bus.mem_rdata = 16'h5555;
    tick();
    chk("t2_c4_mem_en", 32'(bus.mem_en), 32'h0);
    chk("t2_c4_d_done", 32'(bus.d_done), 32'h0);
    tick();
    chk("t2_c5_mem_en",   32'(bus.mem_en),   32'h1);
    chk("t2_c5_mem_addr", 32'(bus.mem_addr), 32'h0080);
    tick();
    chk("t2_c6_i_done", 32'(bus.i_done), 32'h0);
    tick();
    chk("t2_c7_i_done",  32'(bus.i_done),  32'h1);
    chk("t2_c7_i_rdata", 32'(bus.i_rdata), 32'h5555);
    chk("t2_c7_d_rdata", 32'(bus.d_rdata), 32'hAAAA);
    bus.i_req = 1'b0;
    tick();

    // 3: data write
    bus.d_wr = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hBEEF; bus.mem_rdata = 16'h7777;
    tick();
    chk("t3_c1_mem_en",    32'(bus.mem_en),    32'h1);
    chk("t3_c1_mem_wr",    32'(bus.mem_wr),    32'h1);
    chk("t3_c1_mem_addr",  32'(bus.mem_addr),  32'h0100);
    chk("t3_c1_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    tick();
    chk("t3_c2_mem_en",    32'(bus.mem_en),    32'h0);
    chk("t3_c2_mem_wr",    32'(bus.mem_wr),    32'h0);
    chk("t3_c2_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    chk("t3_c2_mem_addr",  32'(bus.mem_addr),  32'h0100);
    tick();
    chk("t3_c3_d_done",  32'(bus.d_done),  32'h1);
    chk("t3_c3_d_rdata", 32'(bus.d_rdata), 32'hAAAA);
    bus.d_wr = 1'b0;
    tick();

    // 4: read and write together is a write; LATENCY=1 finishes one cycle sooner
    bus.d_rd = 1'b1;  bus.d_wr = 1'b1;  bus.d_addr = 16'h0300;  bus.d_wdata = 16'h1111;
    bus1.d_rd = 1'b1; bus1.d_wr = 1'b1; bus1.d_addr = 16'h0300; bus1.d_wdata = 16'h1111;
    bus1.mem_rdata = 16'h9999;
    tick();
    chk("t4_c1_mem_wr",   32'(bus.mem_wr),   32'h1);
    chk("t4_c1_l1_mem_en", 32'(bus1.mem_en), 32'h1);
    chk("t4_c1_l1_mem_wr", 32'(bus1.mem_wr), 32'h1);
    tick();
    chk("t4_c2_l1_d_done", 32'(bus1.d_done), 32'h1);
    chk("t4_c2_l1_d_rdata", 32'(bus1.d_rdata), 32'h0);
    chk("t4_c2_d_done",    32'(bus.d_done),  32'h0);
    bus1.d_rd = 1'b0; bus1.d_wr = 1'b0;
    tick();
    chk("t4_c3_d_done",    32'(bus.d_done),  32'h1);
    chk("t4_c3_l1_d_done", 32'(bus1.d_done), 32'h0);
    bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    tick();

    // 5: reset during WAIT
    bus.i_req = 1'b1; bus.i_addr = 16'h0050; bus.mem_rdata = 16'h2222;
    tick();
    chk("t5_c1_mem_en", 32'(bus.mem_en), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_c3_i_done",   32'(bus.i_done),   32'h0);
    chk("t5_c3_mem_en",   32'(bus.mem_en),   32'h0);
    chk("t5_c3_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("t5_c3_i_rdata",  32'(bus.i_rdata),  32'h0);
    chk("t5_c3_d_rdata",  32'(bus.d_rdata),  32'h0);
    rst = 1'b0; bus.i_req = 1'b0;
    tick();
    chk("t5_c4_i_done", 32'(bus.i_done), 32'h0);
    chk("t5_c4_mem_en", 32'(bus.mem_en), 32'h0);
    bus.d_rd = 1'b1; bus.d_addr = 16'h0400; bus.mem_rdata = 16'h4321;
    tick();
    chk("t5_new_mem_en",   32'(bus.mem_en),   32'h1);
    chk("t5_new_mem_addr", 32'(bus.mem_addr), 32'h0400);
    tick();
    tick();
    chk("t5_new_d_done",  32'(bus.d_done),  32'h1);
    chk("t5_new_d_rdata", 32'(bus.d_rdata), 32'h4321);
    bus.d_rd = 1'b0;
    tick();

    // 6: halt during WAIT of a fetch
    bus.i_req = 1'b1; bus.i_addr = 16'h0060; bus.mem_rdata = 16'h0A0A;
    tick();
    tick();
    bus.halt = 1'b1;
    tick();
    chk("t6_c3_i_done",   32'(bus.i_done),   32'h1);
    chk("t6_c3_i_rdata",  32'(bus.i_rdata),  32'h0A0A);
    chk("t6_c3_mem_dump", 32'(bus.mem_dump), 32'h0);
    bus.i_req = 1'b0; bus.halt = 1'b0;
    tick();
    chk("t6_c4_mem_dump", 32'(bus.mem_dump), 32'h1);
    bus.d_rd = 1'b1; bus.d_addr = 16'h0500;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_halted_mem_en",   32'(bus.mem_en),   32'h0);
      chk("t6_halted_d_stall",  32'(bus.d_stall),  32'h1);
      chk("t6_halted_d_done",   32'(bus.d_done),   32'h0);
      chk("t6_halted_mem_dump", 32'(bus.mem_dump), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
